// File: rtl/philosophy_v_seq_ctrl_if.sv
// philosophy_v_seq_ctrl_if: instruction-memory read port between the
// sequencer (master) and a synchronous, 1-cycle-latency memory (slave).
interface philosophy_v_seq_ctrl_if #(
    parameter int BUS_WIDTH = 32
);
    logic                 mem_rd_en;
    logic [BUS_WIDTH-1:0] mem_addr;
    logic [BUS_WIDTH-1:0] mem_rdata;

    modport master (
        output mem_rd_en,
        output mem_addr,
        input  mem_rdata
    );

    modport slave (
        input  mem_rd_en,
        input  mem_addr,
        output mem_rdata
    );
endinterface

// File: rtl/philosophy_v_seq_ctrl.sv
// philosophy_v_seq_ctrl: multi-cycle sequencer for the core datapath.
// Every instruction walks FETCH -> WAIT -> EXEC -> WB; the sequencer owns pc,
// latches the fetched word into instr and strobes the register-file write.
// Optional feature: define PHILOSOPHY_V_SINGLE_STEP_EN to add a `step` pulse
// input that executes exactly one instruction from IDLE while run is low.
module philosophy_v_seq_ctrl #(
    parameter int BUS_WIDTH = 32,
    parameter int RESET_PC  = 0,
    parameter int I_LENGTH  = 1024
) (
    input  logic                 clk,
    input  logic                 rstb,
    input  logic                 run,
`ifdef PHILOSOPHY_V_SINGLE_STEP_EN
    input  logic                 step,
`endif
    philosophy_v_seq_ctrl_if.master imem,
    output logic [BUS_WIDTH-1:0] instr,
    input  logic [BUS_WIDTH-1:0] alu_result,
    output logic                 rf_wr_en,
    output logic [4:0]           rf_wr_addr,
    output logic [BUS_WIDTH-1:0] rf_wr_data,
    output logic [BUS_WIDTH-1:0] pc,
    output logic                 busy,
    output logic                 halted,
    output logic                 fault,
    output logic [BUS_WIDTH-1:0] retired
);

    localparam logic [6:0]         OP_RTYPE  = 7'b0110011;
    localparam logic [6:0]         OP_SYSTEM = 7'b1110011;
    // One bit wider than pc so pc+4 past the top of the address space still compares correctly.
    localparam logic [BUS_WIDTH:0] PC_LIMIT  = (BUS_WIDTH+1)'(I_LENGTH * 4);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_WAIT,
        ST_EXEC,
        ST_WB,
        ST_HALT
    } state_t;

    state_t               r_state;
    logic [BUS_WIDTH-1:0] r_pc;
    logic [BUS_WIDTH-1:0] r_instr;
    logic [BUS_WIDTH-1:0] r_retired;
    logic                 r_mem_rd_en;
    logic                 r_rf_wr_en;
    logic                 r_busy;
    logic                 r_halted;
    logic                 r_fault;

    logic [BUS_WIDTH:0]   w_pc_next;
    logic                 w_start;
    logic                 w_continue;

    assign w_pc_next = {1'b0, r_pc} + (BUS_WIDTH+1)'(4);

`ifdef PHILOSOPHY_V_SINGLE_STEP_EN
    // Set while the instruction in flight was launched by step rather than run.
    logic                 r_step_mode;

    assign w_start    = run | step;
    assign w_continue = run & ~r_step_mode;
`else
    assign w_start    = run;
    assign w_continue = run;
`endif

    // Sequencer FSM: state, pc, instr, counters and every registered strobe.
    always_ff @(posedge clk) begin
        if (rstb) begin
            r_state     <= ST_IDLE;
            r_pc        <= BUS_WIDTH'(RESET_PC);
            r_instr     <= '0;
            r_retired   <= '0;
            r_mem_rd_en <= 1'b0;
            r_rf_wr_en  <= 1'b0;
            r_busy      <= 1'b0;
            r_halted    <= 1'b0;
            r_fault     <= 1'b0;
`ifdef PHILOSOPHY_V_SINGLE_STEP_EN
            r_step_mode <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking assignments throughout, so every branch below reads
            // the pre-edge values of r_* regardless of statement order.
            // NOTE: single-cycle strobes default low here and are raised only by the
            // transition that enters their state; this keeps them one cycle wide.
            r_mem_rd_en <= 1'b0;
            r_rf_wr_en  <= 1'b0;
            unique case (r_state)
                ST_IDLE: begin
                    if (w_start) begin
                        r_state     <= ST_FETCH;
                        r_mem_rd_en <= 1'b1;
                        r_busy      <= 1'b1;
`ifdef PHILOSOPHY_V_SINGLE_STEP_EN
                        r_step_mode <= ~run;
`endif
                    end
                end
                ST_FETCH: begin
                    r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    r_instr <= imem.mem_rdata;
                    r_state <= ST_EXEC;
                end
                ST_EXEC: begin
                    if (r_instr[6:0] == OP_RTYPE) begin
                        r_state    <= ST_WB;
                        r_rf_wr_en <= (r_instr[11:7] != 5'd0);
                    end else begin
                        r_state  <= ST_HALT;
                        r_busy   <= 1'b0;
                        r_halted <= 1'b1;
                        if (r_instr[6:0] != OP_SYSTEM) begin
                            r_fault <= 1'b1;
                        end
                    end
                end
                ST_WB: begin
                    r_retired <= r_retired + BUS_WIDTH'(1);
`ifdef PHILOSOPHY_V_SINGLE_STEP_EN
                    r_step_mode <= 1'b0;
`endif
                    if (w_pc_next >= PC_LIMIT) begin
                        r_state  <= ST_HALT;
                        r_busy   <= 1'b0;
                        r_halted <= 1'b1;
                        r_fault  <= 1'b1;
                    end else begin
                        r_pc <= w_pc_next[BUS_WIDTH-1:0];
                        if (w_continue) begin
                            r_state     <= ST_FETCH;
                            r_mem_rd_en <= 1'b1;
                        end else begin
                            r_state <= ST_IDLE;
                            r_busy  <= 1'b0;
                        end
                    end
                end
                ST_HALT: begin
                    r_state <= ST_HALT;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign imem.mem_rd_en = r_mem_rd_en;
    assign imem.mem_addr  = {2'b00, r_pc[BUS_WIDTH-1:2]};
    assign instr          = r_instr;
    assign rf_wr_en       = r_rf_wr_en;
    assign rf_wr_addr     = r_instr[11:7];
    assign rf_wr_data     = alu_result;
    assign pc             = r_pc;
    assign busy           = r_busy;
    assign halted         = r_halted;
    assign fault          = r_fault;
    assign retired        = r_retired;

endmodule

// File: tb/tb_philosophy_v_seq_ctrl.sv
// tb_philosophy_v_seq_ctrl: directed and randomized checks of the sequencer.
// The reference model executes a program image instruction by instruction
// (ISA level) and predicts the register writes and final pc/retired/fault.
module tb_philosophy_v_seq_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rstb_a = 1'b1;
    logic run_a  = 1'b0;
    logic rstb_b = 1'b1;
    logic run_b  = 1'b0;
`ifdef PHILOSOPHY_V_SINGLE_STEP_EN
    logic step_a = 1'b0;
    logic step_b = 1'b0;
`endif

    logic [31:0] instr_a, alu_a, rf_wr_data_a, pc_a, retired_a;
    logic [31:0] instr_b, alu_b, rf_wr_data_b, pc_b, retired_b;
    logic [4:0]  rf_wr_addr_a, rf_wr_addr_b;
    logic        rf_wr_en_a, busy_a, halted_a, fault_a;
    logic        rf_wr_en_b, busy_b, halted_b, fault_b;

    philosophy_v_seq_ctrl_if #(.BUS_WIDTH(32)) bus_a ();
    philosophy_v_seq_ctrl_if #(.BUS_WIDTH(32)) bus_b ();

    logic [31:0] mem_a [1024];
    logic [31:0] mem_b [4];
    logic [31:0] img   [1024];

    // Testbench ALU: any fixed function of instr is enough to tag write data.
    function automatic logic [31:0] alu_fn(input logic [31:0] w);
        return {w[15:0], w[31:16]} ^ 32'h9E37_79B9;
    endfunction

    assign alu_a = alu_fn(instr_a);
    assign alu_b = alu_fn(instr_b);

    always @(posedge clk) if (bus_a.mem_rd_en) bus_a.mem_rdata <= mem_a[bus_a.mem_addr[9:0]];
    always @(posedge clk) if (bus_b.mem_rd_en) bus_b.mem_rdata <= mem_b[bus_b.mem_addr[1:0]];

    philosophy_v_seq_ctrl #(.BUS_WIDTH(32), .RESET_PC(0), .I_LENGTH(1024)) dut_a (
        .clk(clk), .rstb(rstb_a), .run(run_a),
`ifdef PHILOSOPHY_V_SINGLE_STEP_EN
        .step(step_a),
`endif
        .imem(bus_a), .instr(instr_a), .alu_result(alu_a),
        .rf_wr_en(rf_wr_en_a), .rf_wr_addr(rf_wr_addr_a), .rf_wr_data(rf_wr_data_a),
        .pc(pc_a), .busy(busy_a), .halted(halted_a), .fault(fault_a), .retired(retired_a)
    );

    philosophy_v_seq_ctrl #(.BUS_WIDTH(32), .RESET_PC(0), .I_LENGTH(4)) dut_b (
        .clk(clk), .rstb(rstb_b), .run(run_b),
`ifdef PHILOSOPHY_V_SINGLE_STEP_EN
        .step(step_b),
`endif
        .imem(bus_b), .instr(instr_b), .alu_result(alu_b),
        .rf_wr_en(rf_wr_en_b), .rf_wr_addr(rf_wr_addr_b), .rf_wr_data(rf_wr_data_b),
        .pc(pc_b), .busy(busy_b), .halted(halted_b), .fault(fault_b), .retired(retired_b)
    );

    int          n_vec = 0;
    int          n_err = 0;
    int          cyc   = 0;
    logic [36:0] wr_qa [$];
    logic [36:0] wr_qb [$];
    logic [36:0] exp_q [$];
    int          exp_pc;
    int          exp_ret;
    logic        exp_fault;
    logic [31:0] exp_instr;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (rf_wr_en_a === 1'b1) wr_qa.push_back({rf_wr_addr_a, rf_wr_data_a});
        if (rf_wr_en_b === 1'b1) wr_qb.push_back({rf_wr_addr_b, rf_wr_data_b});
    endtask

    task automatic img_fill();
        for (int i = 0; i < 1024; i++) img[i] = 32'h0000_0013;
    endtask

    task automatic img_load();
        for (int i = 0; i < 1024; i++) mem_a[i] = img[i];
        for (int i = 0; i < 4; i++) mem_b[i] = img[i];
    endtask

    task automatic reset_a();
        rstb_a = 1'b1;
        run_a  = 1'b0;
        tick();
        rstb_a = 1'b0;
        cyc    = 0;
        wr_qa.delete();
    endtask

    task automatic reset_b();
        rstb_b = 1'b1;
        run_b  = 1'b0;
        tick();
        rstb_b = 1'b0;
        cyc    = 0;
        wr_qb.delete();
    endtask

    // ISA-level reference: execute img from pc 0 until ecall, illegal op or overflow.
    task automatic model_run(input int limit_bytes);
        int          p;
        logic [31:0] w;
        p = 0;
        exp_q.delete();
        exp_ret   = 0;
        exp_fault = 1'b0;
        for (int s = 0; s < 2000; s++) begin
            w = img[p / 4];
            exp_instr = w;
            if (w[6:0] == 7'h33) begin
                if (w[11:7] != 5'd0) exp_q.push_back({w[11:7], alu_fn(w)});
                exp_ret++;
                if (p + 4 >= limit_bytes) begin
                    exp_fault = 1'b1;
                    break;
                end
                p += 4;
            end else begin
                exp_fault = (w[6:0] != 7'h73);
                break;
            end
        end
        exp_pc = p;
    endtask

    task automatic run_until_halt(input bit on_b, input bit rand_run, input int budget);
        int n;
        n = 0;
        while (n < budget && (on_b ? halted_b : halted_a) !== 1'b1) begin
            if (on_b) run_b = rand_run ? ($urandom_range(3) != 0) : 1'b1;
            else      run_a = rand_run ? ($urandom_range(3) != 0) : 1'b1;
            tick();
            n++;
        end
        check(on_b ? "halt_reached_b" : "halt_reached_a", {63'd0, on_b ? halted_b : halted_a}, 64'd1);
    endtask

    task automatic compare_result(input bit on_b);
        logic [36:0] got [$];
        if (on_b) got = wr_qb;
        else      got = wr_qa;
        check("res_wr_count", got.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got.size(); i++) check("res_wr", got[i], exp_q[i]);
        check("res_pc",      on_b ? pc_b : pc_a,           exp_pc);
        check("res_retired", on_b ? retired_b : retired_a, exp_ret);
        check("res_fault",   on_b ? fault_b : fault_a,     exp_fault);
        check("res_instr",   on_b ? instr_b : instr_a,     exp_instr);
        check("res_busy",    on_b ? busy_b : busy_a,       0);
    endtask

    logic [15:0] rd_mask, wr_mask;
    int          halt_cyc;
    logic [31:0] w;
    logic [6:0]  op;

    initial begin
        // Reset values, then add x1,x2,x3 ; ecall with continuous run.
        img_fill();
        img[0] = 32'h0031_00B3;
        img[1] = 32'h0000_0073;
        img_load();
        reset_a();
        check("rst_pc",      pc_a,            0);
        check("rst_instr",   instr_a,         0);
        check("rst_retired", retired_a,       0);
        check("rst_fault",   fault_a,         0);
        check("rst_halted",  halted_a,        0);
        check("rst_busy",    busy_a,          0);
        check("rst_rd_en",   bus_a.mem_rd_en, 0);
        check("rst_wr_en",   rf_wr_en_a,      0);
        run_a    = 1'b1;
        rd_mask  = '0;
        wr_mask  = '0;
        halt_cyc = -1;
        for (int i = 1; i <= 12; i++) begin
            tick();
            rd_mask[i] = bus_a.mem_rd_en;
            wr_mask[i] = rf_wr_en_a;
            if (i == 1) check("t1_addr0", bus_a.mem_addr, 0);
            if (i == 5) check("t1_addr1", bus_a.mem_addr, 1);
            if (i == 4) begin
                check("t1_wr_addr", rf_wr_addr_a, 1);
                check("t1_wr_data", rf_wr_data_a, alu_fn(32'h0031_00B3));
            end
            if (halted_a === 1'b1 && halt_cyc < 0) halt_cyc = i;
        end
        check("t1_rd_mask",  rd_mask,   16'h0022);
        check("t1_wr_mask",  wr_mask,   16'h0010);
        check("t1_halt_cyc", halt_cyc,  8);
        check("t1_fault",    fault_a,   0);
        check("t1_pc",       pc_a,      4);
        check("t1_retired",  retired_a, 1);
        // Reset must leave HALT.
        rstb_a = 1'b1;
        run_a  = 1'b0;
        tick();
        rstb_a = 1'b0;
        check("t1_rst_halted", halted_a, 0);
        check("t1_rst_pc",     pc_a,     0);

        // Unsupported opcode (addi) faults in EXEC.
        img_fill();
        img_load();
        reset_a();
        run_a    = 1'b1;
        wr_mask  = '0;
        halt_cyc = -1;
        for (int i = 1; i <= 6; i++) begin
            tick();
            wr_mask[i] = rf_wr_en_a;
            if (halted_a === 1'b1 && halt_cyc < 0) halt_cyc = i;
        end
        check("t2_halt_cyc", halt_cyc,  4);
        check("t2_fault",    fault_a,   1);
        check("t2_wr_mask",  wr_mask,   0);
        check("t2_retired",  retired_a, 0);

        // rd = x0: write suppressed, still retires.
        img_fill();
        img[0] = 32'h0000_0033;
        img[1] = 32'h0000_0073;
        img_load();
        reset_a();
        run_until_halt(1'b0, 1'b0, 40);
        check("t4_wr_count", wr_qa.size(), 0);
        check("t4_retired",  retired_a,    1);
        check("t4_pc",       pc_a,         4);
        check("t4_fault",    fault_a,      0);

        // run dropped during EXEC of instr 0, then reasserted.
        img_fill();
        img[0] = 32'h0031_02B3;
        img[1] = 32'h0031_0333;
        img[2] = 32'h0000_0073;
        img_load();
        reset_a();
        run_a = 1'b1;
        tick(); tick(); tick();
        run_a = 1'b0;
        tick();
        check("t5_wb_en",   rf_wr_en_a,   1);
        check("t5_wb_addr", rf_wr_addr_a, 5);
        tick();
        check("t5_idle_busy", busy_a,          0);
        check("t5_idle_pc",   pc_a,            4);
        check("t5_idle_rd",   bus_a.mem_rd_en, 0);
        tick(); tick(); tick();
        check("t5_stay_busy",  busy_a,    0);
        check("t5_stay_ret",   retired_a, 1);
        run_a = 1'b1;
        tick();
        check("t5_resume_rd",   bus_a.mem_rd_en, 1);
        check("t5_resume_addr", bus_a.mem_addr,  1);
        run_until_halt(1'b0, 1'b0, 40);
        check("t5_retired",  retired_a,    2);
        check("t5_pc",       pc_a,         8);
        check("t5_wr_count", wr_qa.size(), 2);

        // Reset pulsed during WAIT.
        reset_a();
        run_a = 1'b1;
        tick(); tick();
        rstb_a = 1'b1;
        run_a  = 1'b0;
        tick();
        rstb_a = 1'b0;
        check("t6_busy",    busy_a,     0);
        check("t6_pc",      pc_a,       0);
        check("t6_wr_en",   rf_wr_en_a, 0);
        check("t6_instr",   instr_a,    0);
        tick(); tick(); tick(); tick(); tick();
        check("t6_no_wr",   wr_qa.size(), 0);
        check("t6_idle",    busy_a,       0);

`ifdef PHILOSOPHY_V_SINGLE_STEP_EN
        // One step pulse in IDLE retires exactly one instruction.
        reset_a();
        step_a = 1'b1;
        tick();
        step_a = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        check("st_wr_count", wr_qa.size(), 1);
        check("st_retired",  retired_a,    1);
        check("st_busy",     busy_a,       0);
        check("st_pc",       pc_a,         4);
        check("st_halted",   halted_a,     0);
`endif

        // I_LENGTH=4: four adds then pc overflow fault at pc=12.
        img_fill();
        for (int i = 0; i < 4; i++) img[i] = 32'h0031_0033 | (32'(i + 1) << 7);
        img_load();
        model_run(16);
        reset_b();
        run_until_halt(1'b1, 1'b0, 60);
        compare_result(1'b1);
        check("t3_pc",    pc_b,    12);
        check("t3_fault", fault_b, 1);
        rstb_b = 1'b1;

        // Random programs with random run toggling.
        for (int p = 0; p < 8; p++) begin
            img_fill();
            for (int i = 0; i < int'($urandom_range(12, 1)); i++) begin
                w = $urandom();
                w[11:7] = ($urandom_range(3) == 0) ? 5'd0 : 5'($urandom_range(31));
                w[6:0]  = 7'h33;
                img[i]  = w;
            end
            for (int i = 0; i < 13; i++) begin
                if (img[i][6:0] != 7'h33) begin
                    w  = $urandom();
                    op = 7'($urandom_range(127));
                    if (op == 7'h33) op = 7'h13;
                    w[6:0] = ($urandom_range(1) == 0) ? 7'h73 : op;
                    img[i] = w;
                    break;
                end
            end
            img_load();
            model_run(4096);
            reset_a();
            run_until_halt(1'b0, 1'b1, 800);
            compare_result(1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
